// File: rtl/forth_boot_ctrl_if.sv
// Host byte stream plus imem write port of the forth boot loader.
// Latency: n/a (signal bundle only); backpressure: rx_ready gates rx_valid.
// Ports: master = host/imem side, slave = forth_boot_ctrl.
interface forth_boot_ctrl_if #(
   parameter int AW = 10
);
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [AW-1:0] imem_waddr;
   logic [15:0]   imem_wdata;
   logic          imem_we;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, imem_waddr, imem_wdata, imem_we
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, imem_waddr, imem_wdata, imem_we
   );
endinterface

// File: rtl/forth_boot_ctrl.sv
// Boot loader: takes a length-prefixed little-endian word image from a byte link,
// writes it into imem from address 0, then releases the forth core from reset.
// Latency: imem write one edge after a word's high byte; backpressure: rx_ready=0 in RUN/ERROR.
// Ports: clk, reset (sync, active-high); bus (slave: rx byte stream in, imem write out);
//        boot_req (warm reload request), cpu_reset, busy, error.
// Optional feature: define FORTH_BOOT_CHECKSUM_EN to expect a trailing 16-bit checksum word.
module forth_boot_ctrl #(
   parameter int AW        = 10,
   parameter int MAX_WORDS = 1024
) (
   input  logic             clk,
   input  logic             reset,
   forth_boot_ctrl_if.slave bus,
   input  logic             boot_req,
   output logic             cpu_reset,
   output logic             busy,
   output logic             error
);

   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   localparam logic [2:0] S_HDR_LO = 3'd0;
   localparam logic [2:0] S_HDR_HI = 3'd1;
   localparam logic [2:0] S_DAT_LO = 3'd2;
   localparam logic [2:0] S_DAT_HI = 3'd3;
   localparam logic [2:0] S_RUN    = 3'd6;
   localparam logic [2:0] S_ERROR  = 3'd7;
`ifdef FORTH_BOOT_CHECKSUM_EN
   localparam logic [2:0] S_CK_LO  = 3'd4;
   localparam logic [2:0] S_CK_HI  = 3'd5;
   // State entered once all data words are in.
   localparam logic [2:0] S_TAIL   = S_CK_LO;
`else
   localparam logic [2:0] S_TAIL   = S_RUN;
`endif

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [7:0]    lo_q;
   logic [15:0]   len_q;
   logic [15:0]   cnt_q;
   logic [AW-1:0] addr_q;
   logic [AW-1:0] waddr_q;
   logic [15:0]   wdata_q;
   logic          we_q;
`ifdef FORTH_BOOT_CHECKSUM_EN
   logic [15:0]   sum_q;
`endif

   logic          accept;
   logic [15:0]   word;
   logic          last_word;

   assign bus.rx_ready = (state != S_RUN) && (state != S_ERROR);
   assign accept       = bus.rx_valid && bus.rx_ready;
   // The high byte is on the bus in the same cycle it completes a word.
   assign word         = {bus.rx_data, lo_q};
   assign last_word    = (cnt_q + 16'd1) == len_q;

   assign bus.imem_waddr = waddr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.imem_we    = we_q;

   always_comb begin
      state_nxt = state;
      case (state)
         S_HDR_LO: if (accept) state_nxt = S_HDR_HI;
         S_HDR_HI: begin
            if (accept) begin
               if ({1'b0, word} > MAX_N)
                  state_nxt = S_ERROR;
               else if (word == 16'd0)
                  state_nxt = S_TAIL;
               else
                  state_nxt = S_DAT_LO;
            end
         end
         S_DAT_LO: if (accept) state_nxt = S_DAT_HI;
         S_DAT_HI: if (accept) state_nxt = last_word ? S_TAIL : S_DAT_LO;
`ifdef FORTH_BOOT_CHECKSUM_EN
         S_CK_LO:  if (accept) state_nxt = S_CK_HI;
         S_CK_HI:  if (accept) state_nxt = (word == sum_q) ? S_RUN : S_ERROR;
`endif
         S_RUN:    if (boot_req) state_nxt = S_HDR_LO;
         S_ERROR:  if (boot_req) state_nxt = S_HDR_LO;
         default:  state_nxt = S_HDR_LO;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_HDR_LO;
         lo_q      <= 8'd0;
         len_q     <= 16'd0;
         cnt_q     <= 16'd0;
         addr_q    <= '0;
         waddr_q   <= '0;
         wdata_q   <= 16'd0;
         we_q      <= 1'b0;
         cpu_reset <= 1'b1;
         busy      <= 1'b1;
         error     <= 1'b0;
`ifdef FORTH_BOOT_CHECKSUM_EN
         sum_q     <= 16'd0;
`endif
      end else begin
         state <= state_nxt;
         we_q  <= 1'b0;
         // Status follows the state register one edge late, so the final
         // imem write has committed before the core sees cpu_reset drop.
         cpu_reset <= (state != S_RUN);
         busy      <= (state != S_RUN) && (state != S_ERROR);
         error     <= (state == S_ERROR);

         if (accept) begin
            // Only consumed by the following high-byte state, so latching
            // every accepted byte is harmless.
            lo_q <= bus.rx_data;
            case (state)
               S_HDR_HI: begin
                  len_q  <= word;
                  cnt_q  <= 16'd0;
                  addr_q <= '0;
`ifdef FORTH_BOOT_CHECKSUM_EN
                  sum_q  <= 16'd0;
`endif
               end
               S_DAT_HI: begin
                  we_q    <= 1'b1;
                  waddr_q <= addr_q;
                  wdata_q <= word;
                  addr_q  <= addr_q + AW'(1);
                  cnt_q   <= cnt_q + 16'd1;
`ifdef FORTH_BOOT_CHECKSUM_EN
                  sum_q   <= sum_q + word;
`endif
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_forth_boot_ctrl.sv
// Bench for forth_boot_ctrl: table of images applied in a loop plus reset-mid-load sequence.
// Latency: checks imem strobe one edge after high byte, cpu_reset/error one edge after last byte.
// Backpressure: byte driver holds rx_valid until rx_ready, with random idle gaps.
module tb_forth_boot_ctrl;
   localparam int AW   = 10;
   localparam int MAXW = 1024;
`ifdef FORTH_BOOT_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic boot_req;
   logic cpu_reset;
   logic busy;
   logic error;

   forth_boot_ctrl_if #(.AW(AW)) bus ();

   forth_boot_ctrl #(.AW(AW), .MAX_WORDS(MAXW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .boot_req  (boot_req),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .error     (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   typedef struct {
      int               n;
      logic [2:0][15:0] w;        // first three words; later words are generated
      int               maxgap;
      bit               ck_bad;   // corrupt the checksum word
      bit               boot_mid; // hold boot_req high during the data phase
      bit               exp_err;
   } vec_t;

   wr_t  exp_q[$];
   vec_t vecs[8];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard side: every imem strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.imem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.imem_waddr, bus.imem_wdata);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("imem_waddr", 32'(bus.imem_waddr), 32'(e.addr));
            check("imem_wdata", 32'(bus.imem_wdata), 32'(e.data));
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] word_of(input vec_t v, input int i);
      if (i < 3) return v.w[i];
      return 16'(i * 7) ^ 16'hA5A5;
   endfunction

   // Entered and left at a negedge; byte is taken at the posedge in between.
   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      if (gap > 0) begin
         bus.rx_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      t = 0;
      while (!bus.rx_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.rx_ready) begin
         check("rx_ready_timeout", 32'(bus.rx_ready), 32'd1);
         bus.rx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask

   function automatic int pick_gap(input int maxgap);
      if (maxgap == 0) return 0;
      return int'($urandom_range(maxgap, 0));
   endfunction

   task automatic send_image(input vec_t v);
      logic [15:0] nn;
      logic [15:0] w;
      logic [15:0] sum;
      wr_t         e;
      nn  = 16'(v.n);
      sum = 16'd0;
      send_byte(nn[7:0], pick_gap(v.maxgap));
      send_byte(nn[15:8], pick_gap(v.maxgap));
      if (v.n <= MAXW) begin
         for (int i = 0; i < v.n; i++) begin
            w = word_of(v, i);
            if (v.boot_mid) boot_req = (i != v.n - 1);
            e.addr = AW'(i);
            e.data = w;
            exp_q.push_back(e);
            send_byte(w[7:0], pick_gap(v.maxgap));
            send_byte(w[15:8], pick_gap(v.maxgap));
            sum = sum + w;
         end
         boot_req = 1'b0;
         if (CK_EN) begin
            if (v.ck_bad) sum = sum ^ 16'h0001;
            send_byte(sum[7:0], pick_gap(v.maxgap));
            send_byte(sum[15:8], pick_gap(v.maxgap));
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      send_image(v);
      // Status lags the last accept by one edge.
      check($sformatf("v%0d cpu_reset_hold", idx), 32'(cpu_reset), 32'd1);
      check($sformatf("v%0d error_hold", idx), 32'(error), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d error", idx), 32'(error), 32'(v.exp_err));
      check($sformatf("v%0d cpu_reset", idx), 32'(cpu_reset), 32'(v.exp_err));
      check($sformatf("v%0d rx_ready", idx), 32'(bus.rx_ready), 32'd0);
      check($sformatf("v%0d busy", idx), 32'(busy), 32'd0);
      if (v.exp_err) begin
         bus.rx_data  = 8'h55;
         bus.rx_valid = 1'b1;
         repeat (3) @(negedge clk);
         check($sformatf("v%0d err_no_consume", idx), 32'(bus.rx_ready), 32'd0);
         bus.rx_valid = 1'b0;
      end
      check($sformatf("v%0d writes_done", idx), 32'(exp_q.size()), 32'd0);
      boot_req = 1'b1;
      @(negedge clk);
      boot_req = 1'b0;
      check($sformatf("v%0d reload_ready", idx), 32'(bus.rx_ready), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d reload_cpu_reset", idx), 32'(cpu_reset), 32'd1);
      check($sformatf("v%0d reload_busy", idx), 32'(busy), 32'd1);
      check($sformatf("v%0d reload_error", idx), 32'(error), 32'd0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, " rx_ready"},   32'(bus.rx_ready),   32'd1);
      check({tag, " imem_we"},    32'(bus.imem_we),    32'd0);
      check({tag, " imem_waddr"}, 32'(bus.imem_waddr), 32'd0);
      check({tag, " imem_wdata"}, 32'(bus.imem_wdata), 32'd0);
      check({tag, " cpu_reset"},  32'(cpu_reset),      32'd1);
      check({tag, " busy"},       32'(busy),           32'd1);
      check({tag, " error"},      32'(error),          32'd0);
   endtask

   initial begin
      vec_t v;
      wr_t  e;

      //         n     w {w2, w1, w0}                         gap ckbad mid err
      vecs[0] = '{3,    {16'hE007, 16'h0002, 16'h0001}, 0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{3,    {16'hE007, 16'h0002, 16'h0001}, 5, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{0,    {16'h0000, 16'h0000, 16'h0000}, 0, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{1025, {16'h0000, 16'h0000, 16'h0000}, 0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{1,    {16'h0000, 16'h0000, 16'h1234}, 1, 1'b1, 1'b0, CK_EN};
      vecs[5] = '{3,    {16'h3333, 16'h2222, 16'h1111}, 2, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{1024, {16'hC0DE, 16'h8001, 16'h7FFF}, 0, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{2,    {16'h0000, 16'h0002, 16'hFFFF}, 1, 1'b0, 1'b0, 1'b0};

      reset        = 1'b1;
      boot_req     = 1'b0;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check_reset_values("reset");

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Reset after three data bytes: partial image abandoned, reload from address 0.
      send_byte(8'h03, 0);
      send_byte(8'h00, 0);
      e.addr = '0;
      e.data = 16'h0001;
      exp_q.push_back(e);
      send_byte(8'h01, 0);
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_reset_values("midload_reset");
      v = '{2, {16'h0000, 16'hBBBB, 16'hAAAA}, 0, 1'b0, 1'b0, 1'b0};
      run_vec(v, 8);

      repeat (3) @(negedge clk);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
